// File: rtl/servo_pkg.sv
// Shared types and constants for the servo motion sequencer.
//  - pulse-width limits (us) used as defaults by the sequencer
//  - width_t / step_t payload types and the sequencer state encoding
package servo_pkg;

    localparam int unsigned MIN_US    = 1000;
    localparam int unsigned MAX_US    = 2000;
    localparam int unsigned CENTER_US = 1500;

    localparam int unsigned WIDTH_W = 16;
    localparam int unsigned STEP_W  = 8;

    typedef logic [WIDTH_W-1:0] width_t;
    typedef logic [STEP_W-1:0]  step_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } seq_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running clock divider producing a one-cycle update pulse.
// Ports:
//  clk   in   system clock
//  rst   in   synchronous reset, active-high (count and pulse cleared)
//  tick  out  registered pulse, high in the cycle the count equals DIV-1
module tick_divider #(
    parameter int unsigned DIV = 250_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Count 0..DIV-1; tick is registered one count early so it lines up with DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            if (cnt_q == CNT_W'(DIV - 1)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            tick <= (cnt_q == CNT_W'(DIV - 2));
        end
    end

endmodule

// File: rtl/servo_motion_sequencer.sv
// Slew-rate-limited position controller for the hobby-servo channels.
// Commands set a per-channel target and step; on every update tick one
// shared datapath walks each channel's current width toward its target.
// Ports:
//  clk, rst       clock and synchronous active-high reset
//  cmd_valid/ready, cmd_ch, cmd_width_us, cmd_step_us   command port
//  width_us       current width per channel, ch0 in [15:0]
//  busy           per-channel current != target
//  all_idle       no channel busy and sequencer idle
//  cmd_err        one-cycle pulse after a command to a nonexistent channel
//  tick           one-cycle pulse at each update instant
module servo_motion_sequencer
    import servo_pkg::*;
#(
    parameter int unsigned NUM_CH    = 5,
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned UPDATE_HZ = 200,
    parameter int unsigned MIN_US    = servo_pkg::MIN_US,
    parameter int unsigned MAX_US    = servo_pkg::MAX_US,
    parameter int unsigned CENTER_US = servo_pkg::CENTER_US
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_ch,
    input  logic [15:0]            cmd_width_us,
    input  logic [7:0]             cmd_step_us,
    output logic [NUM_CH*16-1:0]   width_us,
    output logic [NUM_CH-1:0]      busy,
    output logic                   all_idle,
    output logic                   cmd_err,
    output logic                   tick
);

    localparam int unsigned DIV   = CLK_HZ / UPDATE_HZ;
    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_SCAN = SCAN;

    // A full scan plus the tick cycle must fit inside one update period.
    generate
        if (DIV < NUM_CH + 2) begin : g_div_check
            $error("servo_motion_sequencer: DIV must be >= NUM_CH+2");
        end
        if (NUM_CH > 8) begin : g_ch_check
            $error("servo_motion_sequencer: cmd_ch addresses at most 8 channels");
        end
    endgenerate

    width_t tgt_q  [NUM_CH];
    width_t cur_q  [NUM_CH];
    step_t  step_q [NUM_CH];

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NUM_CH-1:0] busy_d;

    logic             accept_c;
    logic             ch_ok_c;
    logic [IDX_W-1:0] cmd_idx_c;
    width_t           cmd_clamped_c;

    width_t           sel_tgt_c;
    width_t           sel_cur_c;
    step_t            sel_step_c;
    logic signed [16:0] diff_c;
    width_t           mag_c;
    width_t           upd_c;

    tick_divider #(
        .DIV (DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign accept_c  = cmd_valid && cmd_ready;
    assign ch_ok_c   = 32'(cmd_ch) < NUM_CH;
    assign cmd_idx_c = IDX_W'(cmd_ch);

    // Clamp the requested width into the legal servo range.
    always_comb begin
        cmd_clamped_c = cmd_width_us;
        if (cmd_width_us < width_t'(MIN_US)) begin
            cmd_clamped_c = width_t'(MIN_US);
        end else if (cmd_width_us > width_t'(MAX_US)) begin
            cmd_clamped_c = width_t'(MAX_US);
        end
    end

    // Shared slew datapath for the channel selected by idx.
    always_comb begin
        sel_tgt_c  = tgt_q[idx_q];
        sel_cur_c  = cur_q[idx_q];
        sel_step_c = step_q[idx_q];
        diff_c     = $signed({1'b0, sel_tgt_c}) - $signed({1'b0, sel_cur_c});
        mag_c      = diff_c[16] ? WIDTH_W'(-diff_c) : WIDTH_W'(diff_c);
        upd_c      = sel_tgt_c;
        if (sel_step_c != '0 && mag_c > width_t'(sel_step_c)) begin
            if (diff_c[16]) begin
                upd_c = sel_cur_c - width_t'(sel_step_c);
            end else begin
                upd_c = sel_cur_c + width_t'(sel_step_c);
            end
        end
    end

    // Next-state: IDLE waits for tick, SCAN visits channels 0..NUM_CH-1.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                if (32'(idx_q) == NUM_CH - 1) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Accepts and scans never overlap, so at most one source touches busy per cycle.
    always_comb begin
        busy_d = busy;
        if (accept_c && ch_ok_c) begin
            busy_d[cmd_idx_c] = (cmd_clamped_c != cur_q[cmd_idx_c]);
        end
        if (state_q == S_SCAN) begin
            busy_d[idx_q] = (upd_c != sel_tgt_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cmd_ready <= 1'b1;
            cmd_err   <= 1'b0;
            busy      <= '0;
            all_idle  <= 1'b1;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                tgt_q[i]  <= width_t'(CENTER_US);
                cur_q[i]  <= width_t'(CENTER_US);
                step_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cmd_ready <= (state_d == S_IDLE);
            cmd_err   <= accept_c && !ch_ok_c;
            busy      <= busy_d;
            all_idle  <= ~|busy_d && (state_d == S_IDLE);
            if (accept_c && ch_ok_c) begin
                tgt_q[cmd_idx_c]  <= cmd_clamped_c;
                step_q[cmd_idx_c] <= cmd_step_us;
            end
            if (state_q == S_SCAN) begin
                cur_q[idx_q] <= upd_c;
            end
        end
    end

    // Flatten current widths onto the output bus.
    generate
        for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_width_out
            assign width_us[g*16 +: 16] = cur_q[g];
        end
    endgenerate

endmodule
